// File: rtl/qinfen_apb3_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qinfen_apb3_master_arbiter
// Purpose  : Round-robin arbiter sharing one APB3 master port among NUM_REQ
//            requesters. Optional ACCESS timeout via QINFEN_APB3_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qinfen_apb3_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDRWIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*32-1:0]         req_wdata,
    input  logic [NUM_REQ*4-1:0]          req_strb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDRWIDTH-1:0]          paddr,
    output logic [31:0]                   pwdata,
    output logic [3:0]                    pstrb,
    input  logic [31:0]                   prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int GW = $clog2(NUM_REQ);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [GW-1:0] c_LAST_RST = GW'(NUM_REQ - 1);

    logic [1:0]           r_state;
    logic [GW-1:0]        r_owner;
    logic [GW-1:0]        r_last_grant;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [ADDRWIDTH-1:0] r_paddr;
    logic [31:0]          r_pwdata;
    logic [3:0]           r_pstrb;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;

    logic                 w_complete;
    logic                 w_arb;
    logic                 w_found;
    logic [GW-1:0]        w_winner;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   w_req_ready;
    logic [NUM_REQ-1:0]   w_owner_oh;

    assign w_complete = (r_state == c_ACCESS) && pready;
    assign w_arb      = (r_state == c_IDLE) || w_complete;

    // Round-robin search starting just after the last granted requester.
    always_comb begin : p_search
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        w_owner_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!preset && w_arb && w_found && (w_winner == GW'(i))) begin
                w_req_ready[i] = 1'b1;
            end
            if (r_owner == GW'(i)) begin
                w_owner_oh[i] = 1'b1;
            end
        end
    end

`ifdef QINFEN_APB3_ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_ACCESS) && !pready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == c_ACCESS) && !pready &&
                       (r_wait_cnt == 16'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state      <= c_IDLE;
            r_owner      <= '0;
            r_last_grant <= c_LAST_RST;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_complete) begin
                r_rsp_valid <= w_owner_oh;
                r_rsp_rdata <= r_pwrite ? 32'd0 : prdata;
                r_rsp_err   <= pslverr;
            end else if (w_timeout) begin
                r_rsp_valid <= w_owner_oh;
                r_rsp_rdata <= 32'd0;
                r_rsp_err   <= 1'b1;
            end

            if (w_arb) begin
                if (w_found) begin
                    r_state      <= c_SETUP;
                    r_psel       <= 1'b1;
                    r_penable    <= 1'b0;
                    r_owner      <= w_winner;
                    r_last_grant <= w_winner;
                    r_pwrite     <= req_write[w_winner];
                    r_paddr      <= req_addr[w_winner*ADDRWIDTH +: ADDRWIDTH];
                    r_pwdata     <= req_wdata[w_winner*32 +: 32];
                    r_pstrb      <= req_write[w_winner] ? req_strb[w_winner*4 +: 4] : 4'd0;
                end else begin
                    r_state   <= c_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            end else if (r_state == c_SETUP) begin
                r_state   <= c_ACCESS;
                r_penable <= 1'b1;
            end else if (w_timeout || (r_state != c_ACCESS)) begin
                r_state   <= c_IDLE;
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_qinfen_apb3_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qinfen_apb3_master_arbiter
// Purpose  : Directed bench for qinfen_apb3_master_arbiter; the timeout case
//            runs only when QINFEN_APB3_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qinfen_apb3_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 12;

    logic              pclk;
    logic              preset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0] req_strb;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    qinfen_apb3_master_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic        err;
        logic [31:0] rdata_in;
        logic [3:0]  e_ready;
        logic        e_psel;
        logic        e_pen;
        logic [11:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [3:0]  e_pstrb;
        logic [3:0]  e_rsp;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [14];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #2;
    endtask

    initial begin
        logic [3:0] grants [6];
        logic [3:0] exp_grants [6];
        int ng;
        int lat;
        bit started;

        // Requester payloads: 0 read 0x020, 1 write 0x010, 2 write 0x030, 3 read 0x040
        req_addr  = {12'h040, 12'h030, 12'h010, 12'h020};
        req_write = 4'b0110;
        req_wdata = {32'hDEAD_0003, 32'hCAFE_0002, 32'hA5A5_0001, 32'h0000_0000};
        req_strb  = {4'hC, 4'h3, 4'hF, 4'h0};
        prdata    = 32'h0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        req_valid = 4'b1111;
        preset    = 1'b1;

        //         valid  rdy err prdata        ready  psel pen paddr   pwdata        strb  rsp    err rdata
        vecs[0]  = '{4'b0010, 1, 0, 32'h0,        4'b0010, 0, 0, 12'h000, 32'h0000_0000, 4'h0, 4'b0000, 0, 32'h0};
        vecs[1]  = '{4'b0000, 1, 0, 32'h0,        4'b0000, 1, 0, 12'h010, 32'hA5A5_0001, 4'hF, 4'b0000, 0, 32'h0};
        vecs[2]  = '{4'b0000, 1, 0, 32'h0,        4'b0000, 1, 1, 12'h010, 32'hA5A5_0001, 4'hF, 4'b0000, 0, 32'h0};
        vecs[3]  = '{4'b0000, 1, 0, 32'h0,        4'b0000, 0, 0, 12'h010, 32'hA5A5_0001, 4'hF, 4'b0010, 0, 32'h0};
        vecs[4]  = '{4'b0100, 1, 0, 32'h0,        4'b0100, 0, 0, 12'h010, 32'hA5A5_0001, 4'hF, 4'b0000, 0, 32'h0};
        vecs[5]  = '{4'b0000, 1, 0, 32'h0,        4'b0000, 1, 0, 12'h030, 32'hCAFE_0002, 4'h3, 4'b0000, 0, 32'h0};
        vecs[6]  = '{4'b1000, 1, 1, 32'h0,        4'b1000, 1, 1, 12'h030, 32'hCAFE_0002, 4'h3, 4'b0000, 0, 32'h0};
        vecs[7]  = '{4'b0000, 1, 0, 32'h0,        4'b0000, 1, 0, 12'h040, 32'hDEAD_0003, 4'h0, 4'b0100, 1, 32'h0};
        vecs[8]  = '{4'b0001, 0, 0, 32'h0,        4'b0000, 1, 1, 12'h040, 32'hDEAD_0003, 4'h0, 4'b0000, 1, 32'h0};
        vecs[9]  = '{4'b0001, 1, 0, 32'h1234_5678, 4'b0001, 1, 1, 12'h040, 32'hDEAD_0003, 4'h0, 4'b0000, 1, 32'h0};
        vecs[10] = '{4'b0000, 1, 0, 32'hFFFF_FFFF, 4'b0000, 1, 0, 12'h020, 32'h0000_0000, 4'h0, 4'b1000, 0, 32'h1234_5678};
        vecs[11] = '{4'b0000, 1, 0, 32'h0BAD_F00D, 4'b0000, 1, 1, 12'h020, 32'h0000_0000, 4'h0, 4'b0000, 0, 32'h1234_5678};
        vecs[12] = '{4'b0000, 1, 0, 32'h0,        4'b0000, 0, 0, 12'h020, 32'h0000_0000, 4'h0, 4'b0001, 0, 32'h0BAD_F00D};
        vecs[13] = '{4'b0000, 1, 0, 32'h0,        4'b0000, 0, 0, 12'h020, 32'h0000_0000, 4'h0, 4'b0000, 0, 32'h0BAD_F00D};

        #3;
        check("reset_outputs",
              {req_ready, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err},
              {4'b0000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 4'b0000, 32'h0, 1'b0});
        req_valid = 4'b0000;
        repeat (2) @(posedge pclk);
        #2 preset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            next_cycle();
            req_valid = vecs[k].valid;
            pready    = vecs[k].rdy;
            pslverr   = vecs[k].err;
            prdata    = vecs[k].rdata_in;
            #1;
            check($sformatf("vec%0d", k),
                  {req_ready, psel, penable, paddr, pwdata, pstrb, rsp_valid, rsp_err, rsp_rdata},
                  {vecs[k].e_ready, vecs[k].e_psel, vecs[k].e_pen, vecs[k].e_paddr, vecs[k].e_pwdata,
                   vecs[k].e_pstrb, vecs[k].e_rsp, vecs[k].e_err, vecs[k].e_rdata});
        end

        // Read from requester 0 with three ACCESS wait states
        next_cycle();
        req_valid = 4'b0001;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        check("rw_grant", req_ready, 4'b0001);
        next_cycle();
        req_valid = 4'b0000;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            pready = (k >= 4);
            prdata = (k == 4) ? 32'h1234_5678 : 32'h5555_AAAA;
            #1;
            if (rsp_valid != 4'b0000) begin
                lat = k;
                break;
            end
            if (k >= 1) begin
                check($sformatf("rw_stable_k%0d", k), {psel, penable, pwrite, paddr, pwdata, pstrb},
                      {1'b1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0});
            end
            next_cycle();
        end
        check("rw_grant_edge_to_rsp", lat, 5);
        check("rw_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b0001, 1'b0, 32'h1234_5678});
        next_cycle();
        pready = 1'b1;

`ifdef QINFEN_APB3_ARB_TIMEOUT_EN
        next_cycle();
        req_valid = 4'b0010;
        pready    = 1'b0;
        #1;
        check("to_grant", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b0000;
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (!psel) break;
            if (penable) lat++;
            next_cycle();
        end
        check("to_access_cycles", lat, 5);
        check("to_rsp", {psel, rsp_valid, rsp_err, rsp_rdata}, {1'b0, 4'b0010, 1'b1, 32'h0});
        next_cycle();
        pready = 1'b1;
`endif

        // Asynchronous reset while ACCESS is waiting
        next_cycle();
        req_valid = 4'b0100;
        pready    = 1'b0;
        #1;
        check("rst_grant", req_ready, 4'b0100);
        next_cycle();
        req_valid = 4'b0000;
        next_cycle();
        next_cycle();
        #1;
        check("rst_in_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        #1;
        check("rst_immediate", {psel, penable, rsp_valid}, {1'b0, 1'b0, 4'b0000});
        next_cycle();
        next_cycle();
        preset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            pready = 1'b1;
            #1;
            check($sformatf("rst_no_stale_%0d", c), {psel, rsp_valid}, {1'b0, 4'b0000});
        end

        // Continuous contention: expect 0,1,2,3,0,1 with no idle gap
        exp_grants = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        next_cycle();
        req_valid = 4'b1111;
        ng = 0;
        started = 1'b0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            #1;
            if (started) check($sformatf("rr_psel_c%0d", c), psel, 1'b1);
            if (req_ready != 4'b0000) begin
                grants[ng] = req_ready;
                ng++;
                started = 1'b1;
            end
            next_cycle();
        end
        check("rr_grant_count", ng, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ng) check($sformatf("rr_grant%0d", i), grants[i], exp_grants[i]);
        end
        req_valid = 4'b0000;
        repeat (4) next_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
